// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state encoding and decode helpers for the M-stage memory sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_seq_state_t;

    localparam logic [1:0] LOAD_SRC = 2'b01;

    function automatic logic is_access(input logic [1:0] result_src, input logic mem_write);
        return mem_write | (result_src == LOAD_SRC);
    endfunction

endpackage

// File: rtl/mem_seq_timeout_ctr.sv
// mem_seq_timeout_ctr: cycle counter with clear/enable; hit flags the TIMEOUT-th enabled cycle.
module mem_seq_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt;

    // hit fires in the cycle whose count brings the total to TIMEOUT
    assign hit = en && (cnt >= 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences M-stage loads/stores over a req/gnt/rvalid bus,
// stalling the pipeline until completion and aborting silent accesses after TIMEOUT cycles.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        ResultSrc_M,
    input  logic              MemWrite_M,
    input  logic [ADDR_W-1:0] ALUResult_M,
    input  logic [DATA_W-1:0] WriteData_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ReadData_M,
    output logic              MemStall_M,
    output logic              MemFault_M
);

    mem_seq_state_t state;
    logic access, hit;

    assign access     = is_access(ResultSrc_M, MemWrite_M);
    assign MemStall_M = access & (state != DONE);

    mem_seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE && access),
        .en    (state == REQ || state == WAIT),
        .hit   (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ReadData_M <= '0;
            MemFault_M <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    MemFault_M <= 1'b0;
                    if (access) begin
                        state     <= REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite_M;
                        mem_addr  <= ALUResult_M;
                        mem_wdata <= WriteData_M;
                    end
                end
                REQ: begin
                    // a grant (or same-cycle read data) beats a coincident timeout
                    if (mem_gnt && (mem_we || mem_rvalid)) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        if (!mem_we)
                            ReadData_M <= mem_rdata;
                    end else if (mem_gnt) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                    end else if (hit) begin
                        state      <= DONE;
                        mem_req    <= 1'b0;
                        ReadData_M <= '0;
                        MemFault_M <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state      <= DONE;
                        ReadData_M <= mem_rdata;
                    end else if (hit) begin
                        state      <= DONE;
                        ReadData_M <= '0;
                        MemFault_M <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    MemFault_M <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
